// File: rtl/md_unit.sv
// Multiply/divide unit owning HI/LO; optional multiply-accumulate ops under MDU_MADD_EN.
// Latency: mult-class ops MULT_CYCLES, div/divu DIV_CYCLES, mthi/mtlo one edge.
// Backpressure: registered Busy covers the whole run; Start while busy is ignored.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] MULT_N = MULT_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DIV_N  = DIV_CYCLES[CNT_W-1:0];

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [63:0] pend_dat;
    logic        pend_vld;

    // Operand datapath: all results are computed from the current A/B so the
    // pending register can capture them at the accepting edge.
    logic [63:0]        a_sx;
    logic [63:0]        b_sx;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               b_zero;
    logic signed [32:0] a33;
    logic signed [32:0] b33;
    logic [31:0]        b_div_u;
    logic [31:0]        div_q;
    logic [31:0]        div_r;
    logic [31:0]        divu_q;
    logic [31:0]        divu_r;

    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};

    // A 33-bit signed divide keeps 0x80000000 / -1 representable; the
    // truncation back to 32 bits yields the architectural wrap value.
    assign b_zero  = (B == 32'd0);
    assign a33     = {A[31], A};
    assign b33     = b_zero ? 33'sd1 : {B[31], B};
    assign b_div_u = b_zero ? 32'd1 : B;
    assign div_q   = 32'(a33 / b33);
    assign div_r   = 32'(a33 % b33);
    assign divu_q  = A / b_div_u;
    assign divu_r  = A % b_div_u;

`ifdef MDU_MADD_EN
    logic [63:0] acc_src;
    assign acc_src = {HI, LO};
`endif

    logic             run_op;
    logic [CNT_W-1:0] run_len;
    logic [63:0]      run_dat;
    logic             run_commit;
    logic             wr_hi;
    logic             wr_lo;

    always_comb begin
        run_op     = 1'b0;
        run_len    = MULT_N;
        run_dat    = 64'd0;
        run_commit = 1'b1;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (MDop)
            OP_MULT: begin
                run_op  = 1'b1;
                run_dat = prod_s;
            end
            OP_MULTU: begin
                run_op  = 1'b1;
                run_dat = prod_u;
            end
            OP_DIV: begin
                run_op     = 1'b1;
                run_len    = DIV_N;
                run_dat    = {div_r, div_q};
                run_commit = !b_zero;
            end
            OP_DIVU: begin
                run_op     = 1'b1;
                run_len    = DIV_N;
                run_dat    = {divu_r, divu_q};
                run_commit = !b_zero;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD: begin
                run_op  = 1'b1;
                run_dat = acc_src + prod_s;
            end
            OP_MADDU: begin
                run_op  = 1'b1;
                run_dat = acc_src + prod_u;
            end
            OP_MSUB: begin
                run_op  = 1'b1;
                run_dat = acc_src - prod_s;
            end
            OP_MSUBU: begin
                run_op  = 1'b1;
                run_dat = acc_src - prod_u;
            end
`endif
            default: ;
        endcase
    end

    logic accept;
    logic commit_now;

    assign accept = (state == IDLE) && Start;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        commit_now = 1'b0;
        case (state)
            IDLE: begin
                if (accept && run_op) begin
                    state_nxt = RUN;
                    cnt_nxt   = run_len;
                end
            end
            RUN: begin
                // Counter holds the remaining busy cycles; the edge that
                // takes it from 1 to 0 is the commit edge.
                if (cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    commit_now = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Busy  <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_dat <= 64'd0;
            pend_vld <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            if (accept && run_op) begin
                pend_dat <= run_dat;
                pend_vld <= run_commit;
            end else if (commit_now) begin
                pend_vld <= 1'b0;
            end

            if (commit_now && pend_vld) begin
                HI <= pend_dat[63:32];
                LO <= pend_dat[31:0];
            end else if (accept) begin
                if (wr_hi) HI <= A;
                if (wr_lo) LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: timing of Busy, HI/LO results, ignored starts, reset.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDop;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_errors = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDop  (MDop),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDop  = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        MDop  = 4'd0;
        A     = 32'hDEAD_BEEF;
        B     = 32'hDEAD_BEEF;
    endtask

    // Counts cycles while Busy is high; bounded so a stuck Busy still ends.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (Busy && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    int n;

    initial begin
        reset = 1'b0;
        Start = 1'b0;
        MDop  = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        tick();
        tick();
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        reset = 1'b1;
        tick();

        // mult -2 * 3
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_hilo_before_commit", {HI, LO}, 64'd0);
        wait_idle(n);
        check("mult_busy_cycles", 64'(n), 64'd5);
        check("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);

        issue(4'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("multu_busy_cycles", 64'(n), 64'd5);
        check("multu_hilo", {HI, LO}, 64'h0000_0002_FFFF_FFFA);

        // div -7 / 2 = -3 rem -1
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_busy_cycles", 64'(n), 64'd10);
        check("div_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(4'd4, 32'd7, 32'd0);
        wait_idle(n);
        check("divu_by0_busy_cycles", 64'(n), 64'd10);
        check("divu_by0_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div_overflow_hilo", {HI, LO}, 64'h0000_0000_8000_0000);

        // 7 / -2 = -3 rem 1
        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        check("div_neg_divisor_hilo", {HI, LO}, 64'h0000_0001_FFFF_FFFD);

        issue(4'd4, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_hilo", {HI, LO}, 64'h0000_0002_0000_000E);

        // mthi then mtlo on consecutive cycles
        issue(4'd5, 32'h1234_5678, 32'd0);
        check("mthi_busy", {63'd0, Busy}, 64'd0);
        check("mthi_hilo", {HI, LO}, 64'h1234_5678_0000_000E);
        issue(4'd6, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_busy", {63'd0, Busy}, 64'd0);
        check("mtlo_hilo", {HI, LO}, 64'h1234_5678_9ABC_DEF0);

        // Start during RUN is ignored (mult and mthi), div commits on schedule
        issue(4'd3, 32'd100, 32'd10);
        n = 0;
        while (Busy && n < 100) begin
            Start = (n == 2 || n == 3);
            MDop  = (n == 2) ? 4'd1 : 4'd5;
            A     = 32'h0000_0333;
            B     = 32'd3;
            tick();
            n++;
        end
        Start = 1'b0;
        MDop  = 4'd0;
        check("ignored_start_busy_cycles", 64'(n), 64'd10);
        check("ignored_start_hilo", {HI, LO}, 64'h0000_0000_0000_000A);

        // accepted on the first non-busy cycle
        issue(4'd2, 32'd4, 32'd5);
        check("b2b_accept_busy", {63'd0, Busy}, 64'd1);
        wait_idle(n);
        check("b2b_busy_cycles", 64'(n), 64'd5);
        check("b2b_hilo", {HI, LO}, 64'h0000_0000_0000_0014);

        // reset on the 3rd busy cycle of a mult
        issue(4'd5, 32'h0000_0055, 32'd0);
        issue(4'd1, 32'd2, 32'd3);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrun_reset_busy", {63'd0, Busy}, 64'd0);
        check("midrun_reset_hilo", {HI, LO}, 64'd0);
        repeat (6) tick();
        check("midrun_reset_no_commit", {HI, LO}, 64'd0);
        check("midrun_reset_idle", {63'd0, Busy}, 64'd0);

        // reset beats a same-cycle Start
        reset = 1'b0;
        issue(4'd5, 32'h0000_0077, 32'd0);
        reset = 1'b1;
        check("reset_vs_start_hi", {32'd0, HI}, 64'd0);

        // reserved codes and none do nothing
        issue(4'd5, 32'hAAAA_0001, 32'd0);
        issue(4'd12, 32'h1111_1111, 32'd1);
        check("reserved_busy", {63'd0, Busy}, 64'd0);
        issue(4'd0, 32'h2222_2222, 32'd1);
        check("none_hilo", {HI, LO}, 64'hAAAA_0001_0000_0000);

        // maddu accumulate vs reserved behaviour
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
        issue(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        check("maddu_busy", {63'd0, Busy}, 64'd1);
        wait_idle(n);
        check("maddu_busy_cycles", 64'(n), 64'd5);
        check("maddu_hilo", {HI, LO}, 64'h0000_0001_0000_0000);
        // msub: 1:0 - (-1 * 2) = 0x1_00000002
        issue(4'd9, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        check("msub_hilo", {HI, LO}, 64'h0000_0001_0000_0002);
`else
        check("maddu_off_busy", {63'd0, Busy}, 64'd0);
        wait_idle(n);
        check("maddu_off_hilo", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
        issue(4'd9, 32'hFFFF_FFFF, 32'd2);
        check("msub_off_busy", {63'd0, Busy}, 64'd0);
        check("msub_off_hilo", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the E pipeline stage. It owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo. It produces the `Busy` indication that the D stage consumes as `E_Busy` to stall HI/LO-dependent instructions. It also supplies HI/LO read data for mfhi/mflo into the E-stage result path.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd/maddu/msub/msubu when enabled).
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clk`.
- `Start`  in  1  one-cycle request; qualifies `MDop`.
- `MDop`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11–15 reserved.
- `A`  in  32  rs operand, already forwarded.
- `B`  in  32  rt operand, already forwarded.
- `Busy`  out  1  registered; high while an operation is in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- States: IDLE, RUN. `reset`=0 forces IDLE, `Busy`=0, `HI`=0, `LO`=0, cycle counter=0, and discards the pending result.
- In IDLE with `Start`=1:
  - mult: {HI,LO} result = signed A×B (64-bit).
  - multu: unsigned A×B.
  - div: LO=signed A/B (truncate toward zero), HI=signed A%B (sign of dividend).
  - divu: unsigned quotient/remainder.
  - For these ops: latch the result into an internal pending register, load the counter with N (MULT_CYCLES or DIV_CYCLES), go to RUN.
- mthi/mtlo with `Start`=1 in IDLE: HI (or LO) ← A at the same edge; no RUN, `Busy` stays 0.
- RUN: the counter decrements each cycle. On the edge where the counter reaches 0, commit pending to HI/LO, clear `Busy`, and return to IDLE.
- Divide by zero (B=0, div/divu): run the full DIV_CYCLES; HI/LO are left unchanged at commit.
- div: 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `Start`=1 while in RUN: ignored entirely, including mthi/mtlo. The stall logic guarantees this never occurs; the bench checks that state is unaffected.
- `Start`=1 with MDop 0, a reserved code, or (macro off) 7–10: no effect.
- `Start`=0: MDop, A, B are don't-care.
- The producer treats `Busy` OR (`Start` AND MDop a HI/LO op) as the D-stage stall condition for HI/LO readers. md_unit itself only drives the registered `Busy`.

## Timing
- `Start` is sampled at edge E0. `Busy`=1 from after E0 through the cycle ending at edge E0+N, i.e., exactly N cycles.
- HI/LO update at E0+N, the same edge where `Busy` falls. New values are visible in the first cycle with `Busy`=0.
- mthi/mtlo: 1-cycle latency, visible after E0.
- A new `Start` is accepted in the first cycle after `Busy` falls. Back-to-back ops therefore occupy N+1 cycles each at minimum.
- `reset` asserted mid-RUN: at that edge `Busy`=0, HI=LO=0, and the pending result is lost.
- `reset` and `Start` in the same cycle: reset wins.
- HI/LO outputs come directly from the registers, with no combinational path from inputs.

## Configuration
- `MDU_MADD_EN` defined:
  - MDop 7–10 are legal and run with MULT_CYCLES.
  - madd/maddu: {HI,LO} ← {HI,LO} + A×B (signed/unsigned).
  - msub/msubu: {HI,LO} ← {HI,LO} − A×B.
  - 64-bit wrap; the accumulate source is {HI,LO} as sampled at E0.
- `MDU_MADD_EN` undefined: MDop 7–10 are treated as reserved (no effect). The accumulate datapath is not synthesized.

## Test plan
- Reset then mult: A=0xFFFFFFFE, B=3, `Start`=1 → `Busy`=1 for exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div: A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 → HI/LO unchanged after 10 cycles.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → HI/LO reflect each value one edge later, and `Busy` never rises.
- `Start` mult during RUN of a div → ignored. The div result commits on schedule; a 2nd `Start` on the first `Busy`=0 cycle is accepted.
- `reset`=0 on the 3rd busy cycle of mult → `Busy`=0 and HI=LO=0 next cycle, with no later commit.
- With `MDU_MADD_EN`: preload HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 → HI=1, LO=0 after 5 cycles. Without the macro, the same MDop leaves HI=0, LO=0xFFFFFFFF and `Busy`=0.
